// File: rtl/vert_timing_ctrl_if.sv
// vert_timing_ctrl_if
// Host configuration port for vert_timing_ctrl.
//   cfg_valid  : host write request
//   cfg_ready  : controller accepts writes (high only while idle)
//   cfg_addr   : field select (0 visible, 1 front porch, 2 sync pulse, 3 whole frame)
//   cfg_wdata  : write data
//   cfg_commit : one-cycle pulse asking for the shadow values to be applied
// With VERT_TIMING_READBACK_EN defined the port also carries:
//   cfg_rd     : shadow read request
//   cfg_rdata  : shadow field selected by cfg_addr, one clock after cfg_rd
//   cfg_rvalid : one-cycle qualifier for cfg_rdata
interface vert_timing_ctrl_if;
    logic       cfg_valid;
    logic       cfg_ready;
    logic [1:0] cfg_addr;
    logic [9:0] cfg_wdata;
    logic       cfg_commit;
`ifdef VERT_TIMING_READBACK_EN
    logic       cfg_rd;
    logic [9:0] cfg_rdata;
    logic       cfg_rvalid;
`endif

`ifdef VERT_TIMING_READBACK_EN
    modport master (
        output cfg_valid, cfg_addr, cfg_wdata, cfg_commit, cfg_rd,
        input  cfg_ready, cfg_rdata, cfg_rvalid
    );
    modport slave (
        input  cfg_valid, cfg_addr, cfg_wdata, cfg_commit, cfg_rd,
        output cfg_ready, cfg_rdata, cfg_rvalid
    );
`else
    modport master (
        output cfg_valid, cfg_addr, cfg_wdata, cfg_commit,
        input  cfg_ready
    );
    modport slave (
        input  cfg_valid, cfg_addr, cfg_wdata, cfg_commit,
        output cfg_ready
    );
`endif
endinterface

// File: rtl/vert_timing_ctrl.sv
// vert_timing_ctrl
// Shadow/active configuration controller for the vertical counter. The host
// writes shadow fields, then commits; a valid commit is held until the next
// rising edge of frm_done so the counter never sees a mid-frame update.
// Optional feature macro: VERT_TIMING_READBACK_EN (shadow readback on cfg).
// Ports:
//   clk                 : system clock
//   nreset              : synchronous active-low reset
//   cfg                 : host configuration port (vert_timing_ctrl_if.slave)
//   frm_done            : frame-done level from the vertical counter
//   vert_cont_registers : {whole[36:27], sync[26:18], fp[17:9], visible[8:0]}
//   cfg_pending         : commit accepted, waiting for a frame boundary
//   cfg_err             : sticky error (bad write or failed commit)
//   upd_done            : one-cycle pulse in the cycle the active set is loaded
//
// state | meaning
// IDLE  | accepting writes and commits
// ARMED | valid commit held, waiting for frame-done rising edge
// APPLY | one cycle: active registers load the shadow set
module vert_timing_ctrl #(
    parameter logic [8:0] DEF_VISIBLE     = 9'd480,
    parameter logic [8:0] DEF_FRONT_PORCH = 9'd490,
    parameter logic [8:0] DEF_SYNC_PULSE  = 9'd492,
    parameter logic [9:0] DEF_WHOLE_FRAME = 10'd524
) (
    input  logic                     clk,
    input  logic                     nreset,
    vert_timing_ctrl_if.slave        cfg,
    input  logic                     frm_done,
    output logic [36:0]              vert_cont_registers,
    output logic                     cfg_pending,
    output logic                     cfg_err,
    output logic                     upd_done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        APPLY = 2'd2
    } state_t;

    state_t     state;
    logic       frm_q;
    logic       frm_evt;

    logic [8:0] sh_vis, sh_fp, sh_sync;
    logic [9:0] sh_whole;
    logic [8:0] act_vis, act_fp, act_sync;
    logic [9:0] act_whole;

    logic       wr_acc, wr_bad, wr_ok;
    logic [8:0] ev_vis, ev_fp, ev_sync;
    logic [9:0] ev_whole;
    logic       commit_ok;

    assign frm_evt = frm_done & ~frm_q;

    assign vert_cont_registers = {act_whole, act_sync, act_fp, act_vis};

    // The commit check sees the shadow set as it will be after this cycle's
    // write, so a write and commit in the same cycle validate together.
    always_comb begin
        wr_acc   = cfg.cfg_valid & cfg.cfg_ready;
        wr_bad   = wr_acc & (cfg.cfg_addr != 2'd3) & cfg.cfg_wdata[9];
        wr_ok    = wr_acc & ~wr_bad;
        ev_vis   = sh_vis;
        ev_fp    = sh_fp;
        ev_sync  = sh_sync;
        ev_whole = sh_whole;
        if (wr_ok) begin
            case (cfg.cfg_addr)
                2'd0:    ev_vis   = cfg.cfg_wdata[8:0];
                2'd1:    ev_fp    = cfg.cfg_wdata[8:0];
                2'd2:    ev_sync  = cfg.cfg_wdata[8:0];
                default: ev_whole = cfg.cfg_wdata;
            endcase
        end
        commit_ok = (ev_vis < ev_fp) && (ev_fp < ev_sync) &&
                    ({1'b0, ev_sync} < ev_whole);
    end

    always_ff @(posedge clk) begin
        if (!nreset) begin
            state         <= IDLE;
            frm_q         <= 1'b0;
            sh_vis        <= DEF_VISIBLE;
            sh_fp         <= DEF_FRONT_PORCH;
            sh_sync       <= DEF_SYNC_PULSE;
            sh_whole      <= DEF_WHOLE_FRAME;
            act_vis       <= DEF_VISIBLE;
            act_fp        <= DEF_FRONT_PORCH;
            act_sync      <= DEF_SYNC_PULSE;
            act_whole     <= DEF_WHOLE_FRAME;
            cfg.cfg_ready <= 1'b1;
            cfg_pending   <= 1'b0;
            cfg_err       <= 1'b0;
            upd_done      <= 1'b0;
        end else begin
            frm_q    <= frm_done;
            upd_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (wr_bad) begin
                        cfg_err <= 1'b1;
                    end
                    if (wr_ok) begin
                        sh_vis   <= ev_vis;
                        sh_fp    <= ev_fp;
                        sh_sync  <= ev_sync;
                        sh_whole <= ev_whole;
                    end
                    if (cfg.cfg_commit) begin
                        if (commit_ok) begin
                            state         <= ARMED;
                            cfg.cfg_ready <= 1'b0;
                            cfg_pending   <= 1'b1;
                        end else begin
                            cfg_err <= 1'b1;
                        end
                    end
                end
                // frm_q is already high if the edge coincided with the commit,
                // so that frame is skipped without extra logic.
                ARMED: begin
                    if (frm_evt) begin
                        state       <= APPLY;
                        cfg_pending <= 1'b0;
                        upd_done    <= 1'b1;
                    end
                end
                APPLY: begin
                    act_vis       <= sh_vis;
                    act_fp        <= sh_fp;
                    act_sync      <= sh_sync;
                    act_whole     <= sh_whole;
                    cfg_err       <= 1'b0;
                    state         <= IDLE;
                    cfg.cfg_ready <= 1'b1;
                end
                default: begin
                    state         <= IDLE;
                    cfg.cfg_ready <= 1'b1;
                    cfg_pending   <= 1'b0;
                end
            endcase
        end
    end

`ifdef VERT_TIMING_READBACK_EN
    always_ff @(posedge clk) begin
        if (!nreset) begin
            cfg.cfg_rdata  <= 10'd0;
            cfg.cfg_rvalid <= 1'b0;
        end else begin
            cfg.cfg_rvalid <= cfg.cfg_rd;
            if (cfg.cfg_rd) begin
                case (cfg.cfg_addr)
                    2'd0:    cfg.cfg_rdata <= {1'b0, sh_vis};
                    2'd1:    cfg.cfg_rdata <= {1'b0, sh_fp};
                    2'd2:    cfg.cfg_rdata <= {1'b0, sh_sync};
                    default: cfg.cfg_rdata <= sh_whole;
                endcase
            end
        end
    end
`endif

endmodule

// File: tb/tb_vert_timing_ctrl.sv
module tb_vert_timing_ctrl;

    logic        clk = 1'b0;
    logic        nreset;
    logic        frm_done;
    logic [36:0] vert_cont_registers;
    logic        cfg_pending, cfg_err, upd_done;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    vert_timing_ctrl_if cfg_bus();

    vert_timing_ctrl dut (
        .clk                 (clk),
        .nreset              (nreset),
        .cfg                 (cfg_bus),
        .frm_done            (frm_done),
        .vert_cont_registers (vert_cont_registers),
        .cfg_pending         (cfg_pending),
        .cfg_err             (cfg_err),
        .upd_done            (upd_done)
    );

    localparam logic [36:0] DEFV = {10'd524, 9'd492, 9'd490, 9'd480};
    localparam logic [36:0] NEWV = {10'd449, 9'd412, 9'd410, 9'd400};

    // Reference model: shadow and active sets as arrays, plus a phase
    // (0 idle, 1 waiting for a frame edge, 2 applying).
    logic [9:0] defs [4];
    logic [9:0] m_sh [4];
    logic [9:0] m_act[4];
    int         m_phase;
    logic       m_frm, m_err, m_upd;
    logic [9:0] m_rdata;
    logic       m_rvalid;

    typedef struct {
        logic        rst_n, valid;
        logic [1:0]  addr;
        logic [9:0]  wdata;
        logic        commit, frm;
        logic        e_ready, e_pend, e_err, e_upd;
        logic [36:0] e_vcr;
    } vec_t;

    vec_t tbl[18];

    function automatic vec_t mk(logic r, logic v, logic [1:0] a, int d, logic c, logic f,
                                logic er, logic ep, logic ee, logic eu, logic [36:0] ev);
        vec_t t;
        t.rst_n = r; t.valid = v; t.addr = a; t.wdata = d[9:0];
        t.commit = c; t.frm = f;
        t.e_ready = er; t.e_pend = ep; t.e_err = ee; t.e_upd = eu; t.e_vcr = ev;
        return t;
    endfunction

    function automatic logic [36:0] pack_act();
        return {m_act[3], m_act[2][8:0], m_act[1][8:0], m_act[0][8:0]};
    endfunction

    function automatic bit ordered(logic [9:0] e[4]);
        for (int i = 0; i < 3; i++)
            if (e[i] >= e[i+1]) return 0;
        return 1;
    endfunction

    task automatic cmp(string nm, logic [63:0] got, logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", nm, $time, got, exp);
        end
    endtask

    task automatic model_next(logic rst_n, logic v, logic [1:0] a, logic [9:0] d,
                              logic c, logic f, logic rd);
        logic [9:0] e[4];
        logic       evt;
        evt = f & ~m_frm;
        if (!rst_n) begin
            m_sh = defs; m_act = defs;
            m_phase = 0; m_err = 0; m_frm = 0; m_upd = 0;
            m_rdata = 0; m_rvalid = 0;
            return;
        end
        m_rvalid = rd;
        if (rd) m_rdata = m_sh[a];
        m_upd = 0;
        if (m_phase == 2) begin
            m_act = m_sh; m_err = 0; m_phase = 0;
        end else if (m_phase == 1) begin
            if (evt) begin m_phase = 2; m_upd = 1; end
        end else begin
            e = m_sh;
            if (v) begin
                if (a != 2'd3 && d[9]) m_err = 1;
                else e[a] = d;
            end
            m_sh = e;
            if (c) begin
                if (ordered(e)) m_phase = 1;
                else m_err = 1;
            end
        end
        m_frm = f;
    endtask

    task automatic step(logic rst_n, logic v, logic [1:0] a, logic [9:0] d,
                        logic c, logic f, logic rd);
        nreset             = rst_n;
        cfg_bus.cfg_valid  = v;
        cfg_bus.cfg_addr   = a;
        cfg_bus.cfg_wdata  = d;
        cfg_bus.cfg_commit = c;
        frm_done           = f;
`ifdef VERT_TIMING_READBACK_EN
        cfg_bus.cfg_rd     = rd;
`endif
        model_next(rst_n, v, a, d, c, f, rd);
        @(posedge clk);
        #1;
    endtask

    task automatic check_model(string nm);
        cmp(nm, {27'd0, vert_cont_registers, cfg_bus.cfg_ready, cfg_pending, cfg_err, upd_done},
                {27'd0, pack_act(), (m_phase == 0), (m_phase == 1), m_err, m_upd});
`ifdef VERT_TIMING_READBACK_EN
        cmp({nm, "_rd"}, {53'd0, cfg_bus.cfg_rvalid, cfg_bus.cfg_rdata}, {53'd0, m_rvalid, m_rdata});
`endif
    endtask

    initial begin
        int upd_cnt;
        logic f;
        logic [1:0] a;
        logic [9:0] d;

        defs = '{10'd480, 10'd490, 10'd492, 10'd524};
        m_frm = 0;
        nreset = 0; frm_done = 0;
        cfg_bus.cfg_valid = 0; cfg_bus.cfg_addr = 0; cfg_bus.cfg_wdata = 0; cfg_bus.cfg_commit = 0;
`ifdef VERT_TIMING_READBACK_EN
        cfg_bus.cfg_rd = 0;
`endif
        repeat (2) @(posedge clk);
        #1;

        //               rst v  a  data  c  f   rdy pnd err upd vcr
        tbl[0]  = mk(0, 0, 0, 0,    0, 0,  1, 0, 0, 0, DEFV);
        tbl[1]  = mk(1, 1, 0, 400,  0, 0,  1, 0, 0, 0, DEFV);
        tbl[2]  = mk(1, 1, 1, 410,  0, 0,  1, 0, 0, 0, DEFV);
        tbl[3]  = mk(1, 1, 2, 412,  0, 0,  1, 0, 0, 0, DEFV);
        tbl[4]  = mk(1, 1, 3, 449,  0, 0,  1, 0, 0, 0, DEFV);
        tbl[5]  = mk(1, 0, 0, 0,    1, 0,  0, 1, 0, 0, DEFV);
        tbl[6]  = mk(1, 0, 0, 0,    0, 0,  0, 1, 0, 0, DEFV);
        tbl[7]  = mk(1, 0, 0, 0,    0, 1,  0, 0, 0, 1, DEFV);
        tbl[8]  = mk(1, 0, 0, 0,    0, 1,  1, 0, 0, 0, NEWV);
        tbl[9]  = mk(1, 0, 0, 0,    0, 0,  1, 0, 0, 0, NEWV);
        tbl[10] = mk(1, 1, 1, 500,  0, 0,  1, 0, 0, 0, NEWV);
        tbl[11] = mk(1, 0, 0, 0,    1, 0,  1, 0, 1, 0, NEWV);
        tbl[12] = mk(1, 1, 1, 410,  0, 0,  1, 0, 1, 0, NEWV);
        tbl[13] = mk(1, 1, 2, 512,  0, 0,  1, 0, 1, 0, NEWV);
        tbl[14] = mk(1, 0, 0, 0,    1, 0,  0, 1, 1, 0, NEWV);
        tbl[15] = mk(1, 1, 0, 1,    1, 0,  0, 1, 1, 0, NEWV);
        tbl[16] = mk(1, 0, 0, 0,    0, 1,  0, 0, 1, 1, NEWV);
        tbl[17] = mk(1, 0, 0, 0,    0, 1,  1, 0, 0, 0, NEWV);

        for (int i = 0; i < 18; i++) begin
            step(tbl[i].rst_n, tbl[i].valid, tbl[i].addr, tbl[i].wdata,
                 tbl[i].commit, tbl[i].frm, 1'b0);
            cmp($sformatf("vec%0d", i),
                {27'd0, vert_cont_registers, cfg_bus.cfg_ready, cfg_pending, cfg_err, upd_done},
                {27'd0, tbl[i].e_vcr, tbl[i].e_ready, tbl[i].e_pend, tbl[i].e_err, tbl[i].e_upd});
            check_model($sformatf("vec%0d_model", i));
        end

        // Commit lands in the same cycle as a frame edge: that edge must not count.
        step(1, 0, 0, 0, 0, 0, 0); check_model("same_pre");
        step(1, 0, 0, 0, 1, 1, 0); check_model("same_commit");
        upd_cnt = 0;
        for (int i = 0; i < 5; i++) begin
            step(1, 0, 0, 0, 0, 1, 0); check_model("same_hold");
            upd_cnt += upd_done;
        end
        cmp("same_edge_no_upd", {63'd0, cfg_pending}, 64'd1);
        cmp("same_edge_upd_cnt", upd_cnt, 0);
        step(1, 0, 0, 0, 0, 0, 0); check_model("same_low");
        step(1, 0, 0, 0, 0, 1, 0); check_model("same_edge");
        cmp("same_next_upd", {63'd0, upd_done}, 64'd1);
        step(1, 0, 0, 0, 0, 1, 0); check_model("same_apply");

        // frm_done held high for 800 cycles: exactly one update.
        step(1, 0, 0, 0, 0, 0, 0); check_model("hold_pre");
        step(1, 1, 0, 300, 1, 0, 0); check_model("hold_commit");
        upd_cnt = 0;
        for (int i = 0; i < 800; i++) begin
            step(1, 0, 0, 0, 0, 1, 0);
            upd_cnt += upd_done;
        end
        check_model("hold_end");
        cmp("hold_upd_cnt", upd_cnt, 1);
        cmp("hold_vcr", {27'd0, vert_cont_registers}, {27'd0, 10'd449, 9'd412, 9'd410, 9'd300});
        step(1, 0, 0, 0, 0, 0, 0); check_model("hold_low");

        // Reset while armed aborts the pending commit.
        step(1, 1, 0, 100, 1, 0, 0); check_model("rst_commit");
        cmp("rst_armed", {63'd0, cfg_pending}, 64'd1);
        step(0, 0, 0, 0, 0, 0, 0); check_model("rst_assert");
        cmp("rst_defaults", {24'd0, vert_cont_registers, cfg_bus.cfg_ready, cfg_pending, cfg_err},
                            {24'd0, DEFV, 1'b1, 1'b0, 1'b0});
        upd_cnt = 0;
        step(1, 0, 0, 0, 0, 0, 0); check_model("rst_rel");
        for (int i = 0; i < 4; i++) begin
            step(1, 0, 0, 0, 0, 1, 0); check_model("rst_frm");
            upd_cnt += upd_done;
        end
        cmp("rst_no_upd", upd_cnt, 0);
        cmp("rst_vcr_hold", {27'd0, vert_cont_registers}, {27'd0, DEFV});

        // Randomized traffic against the model.
        f = 0;
        for (int i = 0; i < 4000; i++) begin
            logic r, v, c, rd;
            r  = ($urandom_range(0, 499) != 0);
            v  = ($urandom_range(0, 2) == 0);
            c  = ($urandom_range(0, 5) == 0);
            rd = ($urandom_range(0, 3) == 0);
            a  = 2'($urandom_range(0, 3));
            case (a)
                2'd0:    d = 10'($urandom_range(0, 150));
                2'd1:    d = 10'($urandom_range(100, 300));
                2'd2:    d = 10'($urandom_range(250, 450));
                default: d = 10'($urandom_range(400, 1023));
            endcase
            if ($urandom_range(0, 15) == 0) d[9] = 1'b1;
            if ($urandom_range(0, 11) == 0) f = ~f;
            step(r, v, a, d, c, f, rd);
            check_model("rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
